// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The master side offers bytes and observes the write/status signals; the
// slave side is the loader itself.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_stall;
    logic              done;
    logic              err;
    logic              loaded;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  core_stall, done, err, loaded
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output core_stall, done, err, loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer. Receives a framed byte stream
// (SYNC, 16-bit word count, little-endian data words, XOR checksum),
// writes each assembled word to consecutive word addresses starting at 0
// and holds the core stalled while a frame is in flight. Every output is
// a register; in_ready depends only on state, never on in_valid.
module imem_loader #(
    parameter int          ADDR_W = 10,
    parameter int          DEPTH  = 1024,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    imem_loader_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // Legal word counts are compared at 17 bits so DEPTH itself is representable.
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    // Running frame checksum: plain XOR over every data byte.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t              state_r;
    logic [7:0]          len_lo_r;
    logic [15:0]         len_r;
    logic [1:0]          byte_cnt_r;
    logic [ADDR_W:0]     word_cnt_r;     // one spare bit: N == DEPTH must not wrap
    logic [23:0]         shift_r;        // first three bytes of the current word
    logic [7:0]          csum_r;
    logic                in_ready_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [31:0]         mem_wdata_r;
    logic                core_stall_r;
    logic                done_r;
    logic                err_r;
    logic                loaded_r;

    logic                accept_s;
    logic [16:0]         len_full_s;
    logic [ADDR_W:0]     word_next_s;
    logic [16:0]         word_next_ext_s;
    logic [16:0]         len_ext_s;

    // Handshake qualifier, candidate length and next word count.
    always_comb begin
        accept_s        = 1'b0;
        len_full_s      = 17'd0;
        word_next_s     = word_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
        word_next_ext_s = 17'(word_next_s);
        len_ext_s       = {1'b0, len_r};
        if (bus.in_valid && in_ready_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        len_full_s = {1'b0, bus.in_data, len_lo_r};
    end

    // Frame FSM with all datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            len_lo_r     <= 8'd0;
            len_r        <= 16'd0;
            byte_cnt_r   <= 2'd0;
            word_cnt_r   <= '0;
            shift_r      <= 24'd0;
            csum_r       <= 8'd0;
            in_ready_r   <= 1'b1;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'd0;
            core_stall_r <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            loaded_r     <= 1'b0;
        end else begin
            mem_we_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s && (bus.in_data == SYNC)) begin
                        err_r        <= 1'b0;
                        word_cnt_r   <= '0;
                        byte_cnt_r   <= 2'd0;
                        csum_r       <= 8'd0;
                        core_stall_r <= 1'b1;
                        state_r      <= S_LEN0;
                    end
                end
                S_LEN0: begin
                    if (accept_s) begin
                        len_lo_r <= bus.in_data;
                        state_r  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept_s) begin
                        len_r <= len_full_s[15:0];
                        if ((len_full_s == 17'd0) || (len_full_s > DEPTH_L)) begin
                            err_r      <= 1'b1;
                            in_ready_r <= 1'b0;
                            state_r    <= S_ERR;
                        end else begin
                            state_r <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        csum_r     <= csum_step(csum_r, bus.in_data);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        shift_r    <= {bus.in_data, shift_r[23:8]};
                        if (byte_cnt_r == 2'd3) begin
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= word_cnt_r[ADDR_W-1:0];
                            mem_wdata_r <= {bus.in_data, shift_r};
                            word_cnt_r  <= word_next_s;
                            if (word_next_ext_s == len_ext_s) begin
                                state_r <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        if (bus.in_data == csum_r) begin
                            done_r   <= 1'b1;
                            loaded_r <= 1'b1;
                            state_r  <= S_DONE;
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= S_ERR;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    in_ready_r   <= 1'b1;
                    core_stall_r <= 1'b0;
                    state_r      <= S_IDLE;
                end
                default: begin
                    in_ready_r   <= 1'b1;
                    core_stall_r <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.core_stall = core_stall_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
    assign bus.loaded     = loaded_r;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the core's word-addressed instruction memory, the write side of the memory the fetch stage reads. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive word addresses. It verifies a trailing XOR checksum and holds the core in stall while a load is in progress.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width.
- `DEPTH`, default 1024: number of instruction-memory words; maximum legal word count.
- `SYNC`, default 8'hA5: frame start byte.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  byte offered.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  byte accepted this cycle when `in_valid & in_ready`.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  word to write.
- `core_stall`  out  1  high while a frame is being loaded.
- `done`  out  1  one-cycle pulse on a successful load.
- `err`  out  1  sticky frame-error flag.
- `loaded`  out  1  sticky; set after the first successful load.

## Operation
- Frame format: `SYNC`, then LEN_LO and LEN_HI (16-bit word count N, little-endian), then N×4 data bytes, then CSUM.
- Data bytes are little-endian within each word; the first byte maps to bits 7:0.
- CSUM is the XOR of all N×4 data bytes. Sync and length bytes are excluded.
- States and transitions:
  - IDLE: accepted bytes other than `SYNC` are discarded. Accepting `SYNC` clears `err`, clears the address counter and checksum, and goes to LEN0.
  - LEN0 → LEN1: capture the low length byte.
  - LEN1: if N==0 or N>DEPTH, go to ERR. Otherwise go to DATA.
  - DATA: a 2-bit byte counter fills the word shift register. On the 4th byte, issue the write and count the word. After word N, go to CSUM.
  - CSUM: if the received byte equals the running XOR, go to DONE. Otherwise go to ERR.
  - DONE: lasts one cycle. Asserts `done`, sets `loaded`, then goes to IDLE.
  - ERR: lasts one cycle. Sets `err`, then goes to IDLE.
- `in_ready` is 1 in IDLE, LEN0, LEN1, DATA and CSUM. It is 0 in DONE and ERR.
- `core_stall` is 1 in LEN0, LEN1, DATA, CSUM, DONE and ERR. It is 0 in IDLE.
- A write issues when the 4th byte of word k (counting from 0) is accepted. On the next cycle `mem_we`=1, `mem_addr`=k, `mem_wdata`=the assembled word.
- The address counter is ADDR_W+1 bits wide, so N==DEPTH does not wrap before the compare.
- There is no rollback. Words written before a checksum error remain in memory, and `loaded` is unchanged.
- Gaps in `in_valid` may occur anywhere in a frame; the state and byte counter simply hold.
- Reset behaviour:
  - In any state, reset forces IDLE.
  - `mem_we`, `mem_addr`, `mem_wdata`, `core_stall`, `done`, `err` and `loaded` all go to 0.
  - `in_ready`=1, because the block is in IDLE.
  - Memory contents are not touched.

## Timing
- `mem_we` is registered: exactly 1 cycle after the handshake of each word's 4th byte. Outside that cycle it is 0.
- `mem_addr` and `mem_wdata` hold their last value when `mem_we`=0.
- `done` and `err` (set) occur 1 cycle after the CSUM byte handshake, or after the LEN_HI handshake for a length error.
- `core_stall` rises the cycle after the `SYNC` handshake. It falls the cycle after DONE or ERR.
- Minimum frame time: 3 + 4N + 1 accepted bytes, plus 1 cycle (DONE/ERR).
- At most one byte is accepted per cycle. No combinational path exists from `in_valid` to `in_ready`.

## Test plan
- Successful load:
  - Stimulus: A5 02 00 13 00 00 00 93 80 20 00 20.
  - Response: writes (0, 0x00000013) and (1, 0x00208093), then `done` pulse, `loaded`=1, `err`=0, `core_stall` drops.
- Bad checksum:
  - Stimulus: the same frame with CSUM 21.
  - Response: both writes still occur, `err`=1, no `done`, `loaded`=0.
- Illegal length:
  - Stimulus: A5 00 00, and separately A5 01 04 (N=1025).
  - Response: `err`=1 after LEN_HI, zero writes, back to IDLE. The next valid frame clears `err`.
- Noise and stalls:
  - Stimulus: FF 00 before the successful-load frame, with random `in_valid` gaps, including mid-word.
  - Response: the noise bytes are discarded; writes and `done` are identical to the successful-load case.
- Reset mid-frame:
  - Stimulus: assert `rst` low after the 5th data byte.
  - Response: all outputs go to reset values immediately, without waiting for a clock edge. A following full frame writes from address 0 and completes correctly.
- Boundary length:
  - Stimulus: N=DEPTH with correct CSUM.
  - Response: the last write is at address DEPTH-1, with no extra write and no wrap; `done`=1.
